hms_mode_ctrl: RTL and testbench
================================

# hms_mode_ctrl

Single-clock mode and setup controller for the HMS digital clock. It replaces gated-clock counter driving with one-cycle increment strobes on the system clock. It decodes three debounced buttons into a mode/position state machine, cascades the 1 Hz tick into sec/min/hour carries, and drives setup increments with hold-to-repeat. It also manages an alarm (arm, match, buzz, silence). It sits between the debounced switches/1 Hz tick NCO and the enable-driven time and alarm counters, and feeds the mode and blink information to the display path.

## Interface
- HOLD_CYC, 50_000_000: clk cycles sw2 must stay held before auto-repeat starts.
- REPEAT_CYC, 10_000_000: clk cycles between auto-repeat strobes.
- BUZZ_SEC, 30: 1 Hz ticks after which the buzzer self-silences.
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- i_tick_1hz  in  1  one-cycle pulse, once per second.
- i_sw0, i_sw1, i_sw2  in  1 each  debounced, active-low buttons: mode, position, increment.
- i_sec_max, i_min_max  in  1 each  level; time seconds == 59 / time minutes == 59.
- i_alarm_match  in  1  level; current time equals alarm time.
- o_mode  out  2  0 CLOCK, 1 SETUP, 2 ALARM.
- o_position  out  2  0 SEC, 1 MIN, 2 HOUR.
- o_sec_inc, o_min_inc, o_hour_inc  out  1 each  one-cycle time-counter enables.
- o_alm_sec_inc, o_alm_min_inc, o_alm_hour_inc  out  1 each  one-cycle alarm-counter enables.
- o_alarm_en  out  1  alarm armed.
- o_buzz  out  1  buzzer drive.
- o_blink  out  1  blank the selected field this half-second.

## Operation
- **Press detection:** a press is a high-to-low transition of i_swN, detected from the registered previous sample. It yields one internal pulse.
- **Press priority:** if presses coincide, sw0 > sw1 > sw2. Lower-priority presses that cycle are dropped.
- **Mode FSM:** CLOCK -> SETUP -> ALARM -> CLOCK on each sw0 press. Encoding 3 is unreachable; if entered, go to CLOCK.
- **Position on mode change:** every mode change resets o_position to SEC.
- **Position FSM:** SEC -> MIN -> HOUR -> SEC on each sw1 press. It is active in SETUP and ALARM; sw1 is ignored in CLOCK.
- **CLOCK and ALARM modes, timekeeping:**
  - o_sec_inc = tick.
  - o_min_inc = tick & i_sec_max.
  - o_hour_inc = tick & i_sec_max & i_min_max.
  - All three are registered.
- **SETUP mode:**
  - Ticks are ignored; time is frozen.
  - An sw2 press strobes only the selected time field. There is no carry into higher fields.
- **ALARM mode:** an sw2 press strobes the selected o_alm_*_inc. Time keeps running.
- **CLOCK mode:** an sw2 press toggles o_alarm_en.
- **Auto-repeat:** applies only in SETUP and ALARM.
  - While sw2 stays low, a counter runs from the press.
  - An extra strobe fires at HOLD_CYC cycles, then every REPEAT_CYC cycles.
  - Release, a mode change, or a position change clears the counter.
- **Alarm trigger:** o_buzz sets on a rising edge of i_alarm_match while o_alarm_en = 1, in CLOCK or ALARM mode.
- **Alarm clear:** o_buzz clears on any button press or after BUZZ_SEC ticks. A press that silences the buzzer is consumed and performs no other action. Clearing o_alarm_en also clears o_buzz.
- **Blink:** o_blink toggles on each tick in SETUP and ALARM. It is forced to 0 in CLOCK and cleared on every mode change.

## Timing
- Reset values: o_mode = CLOCK, o_position = SEC, all inc strobes 0, o_alarm_en = 0, o_buzz = 0, o_blink = 0. Press history registers reset to 1 (released).
- Tick latency: o_*_inc asserts the cycle after i_tick_1hz is sampled high, for exactly one cycle.
- Press latency: let edge E be the first edge that samples i_swN low. The state change or strobe becomes visible after edge E+1, i.e. 2-cycle latency.
- Auto-repeat timing: the first repeat strobe comes HOLD_CYC cycles after the press strobe. Subsequent repeats come every REPEAT_CYC cycles.
- Tick coinciding with sw0: the tick is processed under the pre-change mode. A tick in the same cycle as a CLOCK -> SETUP change still strobes.
- Tick coinciding with an ALARM-mode sw2 strobe: both the time strobe and the alarm strobe fire.
- Reset mid-operation: all state returns to reset values immediately. A button held through reset release is not a press.

## Structure
- Package hms_pkg holds MODE_CLOCK/SETUP/ALARM, POS_SEC/MIN/HOUR, and the 2-bit widths.
- Sub-module sw_press contains the edge detector plus an optional auto-repeat counter (parameter REPEAT_EN). It is instantiated three times; repeat is enabled only for sw2.
- The counter width is $clog2(max(HOLD_CYC, REPEAT_CYC)+1).

## Test plan
Bench parameters: HOLD_CYC = 8, REPEAT_CYC = 4, BUZZ_SEC = 3.
- **Tick cascade:** CLOCK mode, i_sec_max = i_min_max = 1, one tick -> o_sec_inc, o_min_inc and o_hour_inc each high for 1 cycle, one cycle after the tick.
- **Mode and position walk:**
  - sw0 x3 -> o_mode goes 1, 2, 0.
  - In SETUP, sw1 x3 -> o_position goes 1, 2, 0.
  - Each change appears 2 cycles after the press; position returns to 0 on each mode change.
- **SETUP increment and repeat:**
  - Press sw2 at position MIN and hold 20 cycles -> o_min_inc strobes at press+2, press+10, press+14, press+18.
  - A concurrent tick gives no o_sec_inc.
- **Alarm cycle:**
  - CLOCK mode, sw2 -> o_alarm_en = 1.
  - i_alarm_match rises -> o_buzz = 1; after 3 ticks, o_buzz = 0.
  - Repeat, then press sw1 -> o_buzz = 0 and o_position unchanged.
- **Conflicts and reset:**
  - sw0 and sw2 pressed the same cycle -> mode advances and no strobe.
  - Assert rst mid-repeat -> all outputs at reset values on the next sample.
  - Hold sw2 across the reset release -> no strobe.

Source files
------------

// File: rtl/hms_pkg.sv
// Shared encodings for the HMS clock mode/setup controller.
package hms_pkg;
    localparam int MODE_W = 2;
    localparam int POS_W  = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2
    } mode_t;

    typedef enum logic [POS_W-1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;
endpackage

// File: rtl/hms_mode_ctrl_if.sv
// Switch/tick inputs and counter-enable outputs of the HMS mode controller.
// No handshake: every o_*_inc is a one-cycle enable pulse, everything else is a level.
interface hms_mode_ctrl_if;
    import hms_pkg::*;

    logic              i_tick_1hz;
    logic              i_sw0;
    logic              i_sw1;
    logic              i_sw2;
    logic              i_sec_max;
    logic              i_min_max;
    logic              i_alarm_match;
    logic [MODE_W-1:0] o_mode;
    logic [POS_W-1:0]  o_position;
    logic              o_sec_inc;
    logic              o_min_inc;
    logic              o_hour_inc;
    logic              o_alm_sec_inc;
    logic              o_alm_min_inc;
    logic              o_alm_hour_inc;
    logic              o_alarm_en;
    logic              o_buzz;
    logic              o_blink;

    modport master (
        output i_tick_1hz, i_sw0, i_sw1, i_sw2, i_sec_max, i_min_max, i_alarm_match,
        input  o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc,
               o_alm_sec_inc, o_alm_min_inc, o_alm_hour_inc, o_alarm_en, o_buzz, o_blink
    );

    modport slave (
        input  i_tick_1hz, i_sw0, i_sw1, i_sw2, i_sec_max, i_min_max, i_alarm_match,
        output o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc,
               o_alm_sec_inc, o_alm_min_inc, o_alm_hour_inc, o_alarm_en, o_buzz, o_blink
    );
endinterface

// File: rtl/sw_press.sv
// Falling-edge press detector for an active-low debounced button, with optional
// hold-to-repeat pulse generator.
module sw_press #(
    parameter bit REPEAT_EN  = 1'b0,
    parameter int HOLD_CYC   = 8,
    parameter int REPEAT_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic clear,
    output logic press,
    output logic rpt
);
    logic smp;
    logic prev;
    logic primed;

    // First edge after reset loads both stages, so a button held through reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp    <= 1'b1;
            prev   <= 1'b1;
            primed <= 1'b0;
        end else begin
            smp    <= sw;
            prev   <= primed ? smp : sw;
            primed <= 1'b1;
        end
    end

    assign press = prev & ~smp;

    generate
        if (REPEAT_EN) begin : g_rep
            localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
            localparam int CNT_W   = $clog2(CNT_MAX + 1);

            logic             active;
            logic             phase;
            logic [CNT_W-1:0] cnt;

            // phase 0 waits out the hold delay, phase 1 paces the repeats.
            assign rpt = active & ~smp &
                         (phase ? (cnt == CNT_W'(REPEAT_CYC)) : (cnt == CNT_W'(HOLD_CYC)));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    active <= 1'b0;
                    phase  <= 1'b0;
                    cnt    <= '0;
                end else if (clear || smp) begin
                    active <= 1'b0;
                    phase  <= 1'b0;
                    cnt    <= '0;
                end else if (press) begin
                    active <= 1'b1;
                    phase  <= 1'b0;
                    cnt    <= CNT_W'(1);
                end else if (rpt) begin
                    phase <= 1'b1;
                    cnt   <= CNT_W'(1);
                end else if (active) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_norep
            logic unused_clear;
            assign unused_clear = clear;
            assign rpt          = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/hms_mode_ctrl.sv
// Mode/position FSM, tick cascade, setup increments with repeat, and alarm buzz control
// for the HMS digital clock; all counter enables are one-cycle strobes on clk.
import hms_pkg::*;

module hms_mode_ctrl #(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter int BUZZ_SEC   = 30
) (
    input logic           clk,
    input logic           rst,
    hms_mode_ctrl_if.slave bus
);
    localparam int BUZZ_W = $clog2(BUZZ_SEC + 1);

    mode_t             mode, mode_n;
    pos_t              pos, pos_n;
    logic              sec_inc, min_inc, hour_inc, sec_n, min_n, hour_n;
    logic              asec_inc, amin_inc, ahour_inc, asec_n, amin_n, ahour_n;
    logic              alarm_en, alarm_en_n;
    logic              buzz, buzz_n;
    logic [BUZZ_W-1:0] buzz_cnt, buzz_cnt_n;
    logic              blink, blink_n;
    logic              match_q;
    logic              p0, p1, p2, rpt0, rpt1, rpt2;
    logic              clear, evt2, any_evt, match_rise, tick;
    logic              unused_rpt;

    sw_press #(.REPEAT_EN(1'b0), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_sw0 (
        .clk(clk), .rst(rst), .sw(bus.i_sw0), .clear(clear), .press(p0), .rpt(rpt0));
    sw_press #(.REPEAT_EN(1'b0), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_sw1 (
        .clk(clk), .rst(rst), .sw(bus.i_sw1), .clear(clear), .press(p1), .rpt(rpt1));
    sw_press #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_sw2 (
        .clk(clk), .rst(rst), .sw(bus.i_sw2), .clear(clear), .press(p2), .rpt(rpt2));

    assign unused_rpt = rpt0 | rpt1;
    assign tick       = bus.i_tick_1hz;
    // Repeats only matter while editing; in CLOCK sw2 is a one-shot alarm toggle.
    assign evt2       = p2 | (rpt2 & (mode != MODE_CLOCK));
    assign any_evt    = p0 | p1 | evt2;
    assign match_rise = bus.i_alarm_match & ~match_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= MODE_CLOCK;
            pos       <= POS_SEC;
            sec_inc   <= 1'b0;
            min_inc   <= 1'b0;
            hour_inc  <= 1'b0;
            asec_inc  <= 1'b0;
            amin_inc  <= 1'b0;
            ahour_inc <= 1'b0;
            alarm_en  <= 1'b0;
            buzz      <= 1'b0;
            buzz_cnt  <= '0;
            blink     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            mode      <= mode_n;
            pos       <= pos_n;
            sec_inc   <= sec_n;
            min_inc   <= min_n;
            hour_inc  <= hour_n;
            asec_inc  <= asec_n;
            amin_inc  <= amin_n;
            ahour_inc <= ahour_n;
            alarm_en  <= alarm_en_n;
            buzz      <= buzz_n;
            buzz_cnt  <= buzz_cnt_n;
            blink     <= blink_n;
            match_q   <= bus.i_alarm_match;
        end
    end

    always_comb begin
        mode_n     = mode;
        pos_n      = pos;
        sec_n      = 1'b0;
        min_n      = 1'b0;
        hour_n     = 1'b0;
        asec_n     = 1'b0;
        amin_n     = 1'b0;
        ahour_n    = 1'b0;
        alarm_en_n = alarm_en;
        buzz_n     = buzz;
        buzz_cnt_n = buzz_cnt;
        blink_n    = blink;
        clear      = 1'b0;

        // Tick work uses the current (pre-change) mode.
        if (mode != MODE_SETUP && tick) begin
            sec_n  = 1'b1;
            min_n  = bus.i_sec_max;
            hour_n = bus.i_sec_max & bus.i_min_max;
        end
        if (mode == MODE_CLOCK) blink_n = 1'b0;
        else if (tick)          blink_n = ~blink;

        if (buzz && tick) begin
            if (buzz_cnt == BUZZ_W'(BUZZ_SEC - 1)) buzz_n = 1'b0;
            else                                    buzz_cnt_n = buzz_cnt + 1'b1;
        end
        if (alarm_en && match_rise && (mode == MODE_CLOCK || mode == MODE_ALARM)) begin
            buzz_n     = 1'b1;
            buzz_cnt_n = '0;
        end

        // A press that silences the buzzer is swallowed whole.
        if (buzz && any_evt) begin
            buzz_n = 1'b0;
            clear  = 1'b1;
        end else if (p0) begin
            case (mode)
                MODE_CLOCK: mode_n = MODE_SETUP;
                MODE_SETUP: mode_n = MODE_ALARM;
                default:    mode_n = MODE_CLOCK;
            endcase
            pos_n   = POS_SEC;
            blink_n = 1'b0;
            clear   = 1'b1;
        end else if (p1) begin
            if (mode == MODE_SETUP || mode == MODE_ALARM) begin
                case (pos)
                    POS_SEC: pos_n = POS_MIN;
                    POS_MIN: pos_n = POS_HOUR;
                    default: pos_n = POS_SEC;
                endcase
                clear = 1'b1;
            end
        end else if (evt2) begin
            case (mode)
                MODE_SETUP: begin
                    sec_n  = (pos == POS_SEC);
                    min_n  = (pos == POS_MIN);
                    hour_n = (pos == POS_HOUR);
                end
                MODE_ALARM: begin
                    asec_n  = (pos == POS_SEC);
                    amin_n  = (pos == POS_MIN);
                    ahour_n = (pos == POS_HOUR);
                end
                MODE_CLOCK: alarm_en_n = ~alarm_en;
                default: ;
            endcase
        end

        if (!(mode inside {MODE_CLOCK, MODE_SETUP, MODE_ALARM})) begin
            mode_n = MODE_CLOCK;
            pos_n  = POS_SEC;
        end
        if (!(pos inside {POS_SEC, POS_MIN, POS_HOUR})) pos_n = POS_SEC;
        if (!alarm_en_n) buzz_n = 1'b0;
    end

    assign bus.o_mode         = mode;
    assign bus.o_position     = pos;
    assign bus.o_sec_inc      = sec_inc;
    assign bus.o_min_inc      = min_inc;
    assign bus.o_hour_inc     = hour_inc;
    assign bus.o_alm_sec_inc  = asec_inc;
    assign bus.o_alm_min_inc  = amin_inc;
    assign bus.o_alm_hour_inc = ahour_inc;
    assign bus.o_alarm_en     = alarm_en;
    assign bus.o_buzz         = buzz;
    assign bus.o_blink        = blink;
endmodule

// File: tb/tb_hms_mode_ctrl.sv
// Directed bench for hms_mode_ctrl with short hold/repeat/buzz constants.
module tb_hms_mode_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hms_mode_ctrl_if bus();

    always #5 clk = ~clk;

    hms_mode_ctrl #(.HOLD_CYC(8), .REPEAT_CYC(4), .BUZZ_SEC(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [12:0] outs;
    logic [5:0]  incs;
    assign outs = {bus.o_mode, bus.o_position, bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc,
                   bus.o_alm_sec_inc, bus.o_alm_min_inc, bus.o_alm_hour_inc,
                   bus.o_alarm_en, bus.o_buzz, bus.o_blink};
    assign incs = {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc,
                   bus.o_alm_sec_inc, bus.o_alm_min_inc, bus.o_alm_hour_inc};

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_sw(input int idx, input logic v);
        case (idx)
            0:       bus.i_sw0 = v;
            1:       bus.i_sw1 = v;
            default: bus.i_sw2 = v;
        endcase
    endtask

    // Leaves the caller on the sample where the press result is first visible.
    task automatic tap(input int idx);
        set_sw(idx, 1'b0);
        cyc();
        cyc();
        set_sw(idx, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_min;
        bus.i_tick_1hz    = 1'b0;
        bus.i_sw0         = 1'b1;
        bus.i_sw1         = 1'b1;
        bus.i_sw2         = 1'b1;
        bus.i_sec_max     = 1'b0;
        bus.i_min_max     = 1'b0;
        bus.i_alarm_match = 1'b0;

        idle(3);
        chk("reset_outs", 16'(outs), 16'h0);
        rst = 1'b0;
        idle(2);
        chk("post_reset_outs", 16'(outs), 16'h0);

        // Tick cascade in CLOCK
        bus.i_sec_max = 1'b1; bus.i_min_max = 1'b1; bus.i_tick_1hz = 1'b1;
        cyc();
        bus.i_tick_1hz = 1'b0;
        chk("tick_cascade_all", 16'(incs), 16'b111000);
        cyc();
        chk("tick_one_cycle", 16'(incs), 16'h0);
        bus.i_sec_max = 1'b0; bus.i_min_max = 1'b0; bus.i_tick_1hz = 1'b1;
        cyc();
        bus.i_tick_1hz = 1'b0;
        chk("tick_sec_only", 16'(incs), 16'b100000);
        bus.i_sec_max = 1'b1; bus.i_tick_1hz = 1'b1;
        cyc();
        bus.i_tick_1hz = 1'b0; bus.i_sec_max = 1'b0;
        chk("tick_sec_min", 16'(incs), 16'b110000);
        chk("clock_blink", 16'(bus.o_blink), 16'h0);
        idle(2);

        // Mode and position walk
        tap(1);
        chk("clock_sw1_ignored", 16'(bus.o_position), 16'h0);
        idle(2);
        set_sw(0, 1'b0);
        cyc();
        chk("mode_lat1", 16'(bus.o_mode), 16'h0);
        cyc();
        chk("mode_setup", 16'(bus.o_mode), 16'h1);
        set_sw(0, 1'b1);
        idle(2);
        tap(1); chk("pos_min", 16'(bus.o_position), 16'h1);  idle(2);
        tap(1); chk("pos_hour", 16'(bus.o_position), 16'h2); idle(2);
        tap(1); chk("pos_sec", 16'(bus.o_position), 16'h0);  idle(2);
        tap(1); idle(2);
        tap(0);
        chk("mode_alarm", 16'(bus.o_mode), 16'h2);
        chk("mode_alarm_pos", 16'(bus.o_position), 16'h0);
        idle(2);
        tap(0);
        chk("mode_clock", 16'(bus.o_mode), 16'h0);
        idle(2);

        // SETUP increment with hold-to-repeat at MIN
        tap(0); idle(2);
        tap(1); idle(2);
        chk("setup_at_min", 16'({bus.o_mode, bus.o_position}), 16'b0101);
        set_sw(2, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            cyc();
            exp_min = (k == 2 || k == 10 || k == 14 || k == 18);
            chk($sformatf("setup_rep_%0d", k), 16'(incs), 16'({1'b0, exp_min, 4'b0000}));
            if (k == 4) bus.i_tick_1hz = 1'b1;
            if (k == 5) begin
                bus.i_tick_1hz = 1'b0;
                chk("setup_blink", 16'(bus.o_blink), 16'h1);
            end
            if (k == 20) set_sw(2, 1'b1);
        end
        idle(2);

        // ALARM: sw2 strobe and tick together
        tap(0);
        chk("alarm_mode_pos", 16'({bus.o_mode, bus.o_position}), 16'b1000);
        chk("alarm_blink_clr", 16'(bus.o_blink), 16'h0);
        idle(2);
        set_sw(2, 1'b0);
        cyc();
        bus.i_tick_1hz = 1'b1;
        cyc();
        chk("alarm_tick_and_inc", 16'(incs), 16'b100100);
        chk("alarm_blink", 16'(bus.o_blink), 16'h1);
        bus.i_tick_1hz = 1'b0;
        set_sw(2, 1'b0 | 1'b1);
        cyc();
        chk("alarm_inc_one_cycle", 16'(incs), 16'h0);
        idle(2);
        tap(0);
        chk("back_clock", 16'({bus.o_mode, bus.o_blink}), 16'h0);
        idle(2);

        // Alarm arm, trigger, timeout
        tap(2);
        chk("alarm_armed", 16'(bus.o_alarm_en), 16'h1);
        idle(2);
        bus.i_alarm_match = 1'b1;
        cyc();
        chk("buzz_on", 16'(bus.o_buzz), 16'h1);
        for (int t = 1; t <= 3; t++) begin
            bus.i_tick_1hz = 1'b1;
            cyc();
            bus.i_tick_1hz = 1'b0;
            cyc();
            chk($sformatf("buzz_after_tick_%0d", t), 16'(bus.o_buzz), 16'((t < 3) ? 1 : 0));
        end
        bus.i_alarm_match = 1'b0;
        cyc();
        tap(0); idle(2);
        tap(0); idle(2);
        chk("alarm_mode_again", 16'(bus.o_mode), 16'h2);
        bus.i_alarm_match = 1'b1;
        cyc();
        chk("buzz_in_alarm", 16'(bus.o_buzz), 16'h1);
        tap(1);
        chk("silence_buzz", 16'(bus.o_buzz), 16'h0);
        chk("silence_pos", 16'(bus.o_position), 16'h0);
        chk("silence_keeps_en", 16'(bus.o_alarm_en), 16'h1);
        idle(2);
        bus.i_alarm_match = 1'b0;
        tap(0); idle(2);
        tap(2);
        chk("alarm_disarmed", 16'(bus.o_alarm_en), 16'h0);
        idle(2);

        // sw0 and sw2 together: mode wins, sw2 dropped with no repeats
        set_sw(0, 1'b0);
        set_sw(2, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            cyc();
            chk($sformatf("conflict_incs_%0d", k), 16'(incs), 16'h0);
            if (k == 2) begin
                chk("conflict_mode", 16'(bus.o_mode), 16'h1);
                chk("conflict_alarm_en", 16'(bus.o_alarm_en), 16'h0);
                set_sw(0, 1'b1);
            end
        end
        set_sw(2, 1'b1);
        idle(2);

        // Reset mid-repeat, sw2 held through reset release
        set_sw(2, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 2) chk("pre_rst_sec_inc", 16'(incs), 16'b100000);
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 16'(outs), 16'h0);
        idle(2);
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            chk($sformatf("held_thru_rst_%0d", k),
                16'({incs, bus.o_alarm_en, bus.o_mode}), 16'h0);
        end
        set_sw(2, 1'b1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
